// File: rtl/compressor_pkg.sv
// Shared types, constants and helpers for the 8x8 compressor tile sequencer.
// Holds the sequencer state encoding, the JPEG zigzag scan table and the bus packing helper.
package compressor_pkg;

   localparam int TILE_N = 64;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } seq_state_e;

   // Entry i is the row-major (r*8+c) position of the i-th coefficient in JPEG zigzag order.
   localparam logic [5:0] ZIGZAG [TILE_N] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   // LSB position of element k on a flattened bus of w-bit words.
   function automatic int unsigned word_lsb(input logic [5:0] k, input int unsigned w);
      return 32'(k) * w;
   endfunction

endpackage

// File: rtl/zigzag_index_rom.sv
// Combinational lookup from zigzag scan position to row-major tile index.
module zigzag_index_rom
   import compressor_pkg::*;
(
   input  logic [5:0] idx_i,
   output logic [5:0] lin_idx_o
);

   // Table lookup.
   always_comb begin
      lin_idx_o = ZIGZAG[idx_i];
   end

endmodule

// File: rtl/compressor_block_sequencer.sv
// Feeds one 8x8 tile at a time into the compressor pipeline and streams the
// resulting coefficients back out in zigzag order.
module compressor_block_sequencer #(
   parameter int WORD_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WORD_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [64*WORD_W-1:0]  tile_a,
   output logic                  comp_rst,
   output logic                  comp_en,
   input  logic                  comp_valid,
   input  logic [64*WORD_W-1:0]  coef_b,
   output logic [WORD_W-1:0]     out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  timeout_err
);
   import compressor_pkg::*;

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   seq_state_e           state_q, state_d;
   logic [5:0]           cnt_q, cnt_d;
   logic [5:0]           idx_q, idx_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic                 timeout_err_q, timeout_err_d;
   logic [64*WORD_W-1:0] tile_q;
   logic [64*WORD_W-1:0] coef_q;
   logic                 tile_we_s;
   logic                 coef_we_s;
   logic                 in_ready_s;
   logic                 out_valid_s;
   logic [5:0]           lin_idx_s;
   logic [WORD_W-1:0]    out_word_s;

   zigzag_index_rom u_zigzag_rom (
      .idx_i     (idx_q),
      .lin_idx_o (lin_idx_s)
   );

   // Handshake-facing strobes are forced to their reset values while reset is held.
   assign in_ready_s  = (state_q == LOAD) & ~reset;
   assign out_valid_s = (state_q == DRAIN) & ~reset;

   // Next-state and datapath enables for the LOAD/CLEAR/RUN/DRAIN sequence.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      timer_d       = timer_q;
      timeout_err_d = timeout_err_q;
      tile_we_s     = 1'b0;
      coef_we_s     = 1'b0;
      case (state_q)
         LOAD: begin
            if (in_valid && in_ready_s) begin
               tile_we_s = 1'b1;
               if (cnt_q == 6'd63) begin
                  cnt_d   = 6'd0;
                  state_d = CLEAR;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         CLEAR: begin
            timer_d = '0;
            state_d = RUN;
         end
         RUN: begin
            // A valid arriving on the timeout cycle still wins.
            if (comp_valid) begin
               coef_we_s = 1'b1;
               idx_d     = 6'd0;
               state_d   = DRAIN;
            end else if (timer_q == TMR_LAST) begin
               timeout_err_d = 1'b1;
               state_d       = LOAD;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (idx_q == 6'd63) begin
                  idx_d   = 6'd0;
                  state_d = LOAD;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= LOAD;
         cnt_q         <= 6'd0;
         idx_q         <= 6'd0;
         timer_q       <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         timer_q       <= timer_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Tile register; only written in LOAD so it stays frozen through CLEAR and RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         tile_q <= '0;
      end else if (tile_we_s) begin
         tile_q[word_lsb(cnt_q, WORD_W) +: WORD_W] <= in_data;
      end else begin
         tile_q <= tile_q;
      end
   end

   // Coefficient capture on the first compressor valid seen in RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         coef_q <= '0;
      end else if (coef_we_s) begin
         coef_q <= coef_b;
      end else begin
         coef_q <= coef_q;
      end
   end

   // Zigzag-ordered output word, zero whenever nothing is being offered.
   always_comb begin
      if (out_valid_s) begin
         out_word_s = coef_q[word_lsb(lin_idx_s, WORD_W) +: WORD_W];
      end else begin
         out_word_s = '0;
      end
   end

   assign in_ready    = in_ready_s;
   assign tile_a      = tile_q;
   assign comp_rst    = reset | (state_q == CLEAR);
   assign comp_en     = (state_q == RUN) & ~reset;
   assign out_valid   = out_valid_s;
   assign out_data    = out_word_s;
   assign out_last    = out_valid_s & (idx_q == 6'd63);
   assign busy        = ~reset & ~((state_q == LOAD) & (cnt_q == 6'd0));
   assign timeout_err = timeout_err_q & ~reset;

endmodule

// File: tb/tb_compressor_block_sequencer.sv
// Scoreboard bench for compressor_block_sequencer with a behavioural compressor
// that raises valid 5 cycles after enable and returns B = A.
module tb_compressor_block_sequencer;

   localparam int W  = 32;
   localparam int TO = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [W-1:0]      in_data;
   logic              in_valid;
   logic              in_ready;
   logic [64*W-1:0]   tile_a;
   logic              comp_rst;
   logic              comp_en;
   logic              comp_valid;
   logic [64*W-1:0]   coef_b;
   logic [W-1:0]      out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              timeout_err;

   logic [2:0]        mcnt = 3'd0;
   bit                suppress = 1'b0;

   int                n_chk  = 0;
   int                n_pass = 0;
   int                cyc    = 0;
   int                zz [64];
   int unsigned       exp_q [$];
   int unsigned       v [64];

   always #5 clk = ~clk;

   compressor_block_sequencer #(
      .WORD_W         (W),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .tile_a      (tile_a),
      .comp_rst    (comp_rst),
      .comp_en     (comp_en),
      .comp_valid  (comp_valid),
      .coef_b      (coef_b),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   // Compressor model: pipeline of depth 5, cleared by comp_rst.
   always @(posedge clk) begin
      if (comp_rst)
         mcnt <= 3'd0;
      else if (comp_en && mcnt < 3'd5)
         mcnt <= mcnt + 3'd1;
   end
   assign comp_valid = (mcnt == 3'd5) && !suppress;
   assign coef_b     = tile_a;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic run_tile(input int unsigned vals [64], input bit gaps, input bit bp,
                           input bit stall_model, input int rst_after, input bit exp_err);
      int s = 0, wcnt = 0, acc_cyc = 0, rst_cnt = 0, rst_cyc = 0, en_cnt = 0;
      int first_ov = -1, pc = 0, nbad;
      bit held_v = 1'b0, done = 1'b0, rst_done = 1'b0;
      logic [31:0] held = '0;
      suppress = stall_model;
      if (!stall_model)
         for (int i = 0; i < 64; i++) exp_q.push_back(vals[zz[i]]);
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         cyc++;
         if (comp_rst) begin
            rst_cnt++;
            rst_cyc = cyc;
            if (rst_cnt == 1) begin
               nbad = 0;
               for (int i = 0; i < 64; i++)
                  if (tile_a[i*W +: W] !== vals[i]) nbad++;
               check("tile_a_slots", nbad, 0);
            end
         end
         if (comp_en) en_cnt++;
         if (s == 64 && in_ready) begin
            done = 1'b1;
            break;
         end
         out_ready = bp ? (pc % 4 == 0 || pc % 4 == 3) : 1'b1;
         pc++;
         if (held_v) check("stall_hold", out_data, held);
         held_v = 1'b0;
         if (out_valid) begin
            if (first_ov < 0) first_ov = cyc;
            if (rst_after >= 0 && wcnt == rst_after) begin
               out_ready = 1'b0;
               reset = 1'b1;
               #1;
               check("rst_in_ready", in_ready, 0);
               check("rst_comp_rst", comp_rst, 1);
               check("rst_out_valid", out_valid, 0);
               @(negedge clk);
               reset = 1'b0;
               #1;
               check("post_rst_out_valid", out_valid, 0);
               check("post_rst_in_ready", in_ready, 1);
               check("post_rst_busy", busy, 0);
               exp_q.delete();
               done = 1'b1;
               rst_done = 1'b1;
               break;
            end
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  check("spurious_word", out_valid, 0);
               end else begin
                  check($sformatf("word%0d", wcnt), out_data, exp_q.pop_front());
                  check("out_last", out_last, wcnt == 63);
               end
               wcnt++;
            end else begin
               held   = out_data;
               held_v = 1'b1;
            end
         end
         if (s < 64) begin
            in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_data  = vals[s];
            if (in_valid && in_ready) begin
               if (s == 63) acc_cyc = cyc;
               s++;
            end
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         check("tile_budget", in_ready, 1);
      end else if (!rst_done) begin
         check("rst_pulses", rst_cnt, 1);
         check("rst_offset", rst_cyc - acc_cyc, 1);
         if (!stall_model) begin
            check("word_count", wcnt, 64);
            check("first_valid_latency", first_ov - acc_cyc, 8);
            check("run_cycles", en_cnt, 6);
         end else begin
            check("word_count", wcnt, 0);
            check("timeout_latency", cyc - acc_cyc, 18);
            check("run_cycles", en_cnt, 16);
         end
      end
      check("timeout_err", timeout_err, exp_err);
      exp_q.delete();
      suppress = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      n = 0;
      for (int sd = 0; sd < 15; sd++)
         for (int j = 0; j < 8; j++) begin
            int r, c;
            r = (sd % 2 == 1) ? j : 7 - j;
            c = sd - r;
            if (c >= 0 && c < 8) begin
               zz[n] = r * 8 + c;
               n++;
            end
         end

      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_comp_rst", comp_rst, 1);
      check("rst_comp_en", comp_en, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_tile_a_zero", tile_a == '0, 1);
      reset = 1'b0;
      #1;
      check("idle_comp_rst", comp_rst, 0);
      check("idle_in_ready", in_ready, 1);

      for (int i = 0; i < 64; i++) v[i] = i;
      run_tile(v, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      for (int i = 0; i < 64; i++) v[i] = i * 3 + 7;
      run_tile(v, 1'b0, 1'b1, 1'b0, -1, 1'b0);
      for (int i = 0; i < 64; i++) v[i] = $urandom;
      run_tile(v, 1'b1, 1'b0, 1'b0, -1, 1'b0);
      for (int i = 0; i < 64; i++) v[i] = 32'h1000 + i;
      run_tile(v, 1'b0, 1'b0, 1'b1, -1, 1'b1);
      for (int i = 0; i < 64; i++) v[i] = 32'h2000 + i;
      run_tile(v, 1'b1, 1'b1, 1'b0, -1, 1'b1);
      for (int i = 0; i < 64; i++) v[i] = 500 + i;
      run_tile(v, 1'b0, 1'b0, 1'b0, 10, 1'b0);
      for (int i = 0; i < 64; i++) v[i] = i;
      run_tile(v, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      for (int i = 0; i < 64; i++) v[i] = 100 + i;
      run_tile(v, 1'b0, 1'b0, 1'b0, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
